// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between instruction fetch (IF)
// and load/store (LS). At most one access is in flight at a time. Each read response is
// routed back to its owner MEM_LAT cycles after issue. LS has priority over IF.
// Optional macro ARB_STARVE_GUARD_EN: after MAX_WAIT consecutive denied cycles, IF
// overrides LS priority. Without the macro, LS priority is strict and IF may starve.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    // fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    // load/store port
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    // memory port
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned LAT_W = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]       state_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic             owner_ls_q;
    logic             is_store_q;

    logic rsp_cycle;
    logic arb_en;
    logic if_force;
    logic if_win;
    logic ls_win;
    logic rsp_valid;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned WC_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WC_W-1:0] wait_cnt_q;

    // IF overrides LS once it has been denied MAX_WAIT times in a row
    always_comb begin
        if_force = if_req && (wait_cnt_q >= WC_W'(MAX_WAIT));
    end

    // Count consecutive denied IF cycles; saturate, clear on grant or withdrawal
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (!if_req || if_win) begin
            wait_cnt_q <= '0;
        end else if (arb_en && (wait_cnt_q < WC_W'(MAX_WAIT))) begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
        end
    end
`else
    // Strict LS priority: IF never overrides
    always_comb begin
        if_force = 1'b0;
    end
`endif

    // Arbitration: open when idle or in the response cycle of the outstanding access
    always_comb begin
        rsp_cycle = (state_q == WAIT) && (lat_cnt_q == '0);
        arb_en    = !reset && ((state_q == IDLE) || rsp_cycle);
        if_win    = arb_en && if_req && (if_force || !ls_req);
        ls_win    = arb_en && ls_req && !if_win;
        rsp_valid = !reset && rsp_cycle;
    end

    // Drive memory and requester outputs from the winner and the outstanding owner
    always_comb begin
        if_gnt    = if_win;
        ls_gnt    = ls_win;
        mem_en    = if_win || ls_win;
        mem_we    = ls_win && ls_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (ls_win) begin
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_be    = ls_be;
        end else if (if_win) begin
            mem_addr  = if_addr;
            mem_be    = '1;
        end
        if_rvalid = rsp_valid && !owner_ls_q;
        ls_rvalid = rsp_valid && owner_ls_q;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        // Store acks return zero data
        ls_rdata  = (ls_rvalid && !is_store_q) ? mem_rdata : '0;
    end

    // Track the single outstanding access; a grant in the response cycle re-arms the timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            owner_ls_q <= 1'b0;
            is_store_q <= 1'b0;
        end else if (if_win || ls_win) begin
            state_q    <= WAIT;
            lat_cnt_q  <= LAT_W'(MEM_LAT - 1);
            owner_ls_q <= ls_win;
            is_store_q <= ls_win && ls_we;
        end else if (state_q == WAIT) begin
            if (lat_cnt_q == '0) begin
                state_q <= IDLE;
            end else begin
                lat_cnt_q <= lat_cnt_q - LAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) each with a behavioural
// memory. Every cycle is checked against a transaction-level reference model, with directed
// scenarios first and then randomized traffic. Follows ARB_STARVE_GUARD_EN if defined.
module tb_mem_arbiter;

    localparam int unsigned MAX_WAIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        ls_req    [2];
    logic        ls_we     [2];
    logic [31:0] ls_addr   [2];
    logic [31:0] ls_wdata  [2];
    logic [3:0]  ls_be     [2];
    logic        ls_gnt    [2];
    logic        ls_rvalid [2];
    logic [31:0] ls_rdata  [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_be    [2];
    logic [31:0] mem_rdata [2];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(MAX_WAIT)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]), .ls_wdata(ls_wdata[0]),
        .ls_be(ls_be[0]), .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(MAX_WAIT)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]), .ls_wdata(ls_wdata[1]),
        .ls_be(ls_be[1]), .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1])
    );

    // Environment memory (driven by actual DUT mem_* outputs)
    logic [31:0] env_mem [2][256];
    logic [31:0] pipe    [2][3];

    // Reference model state
    logic [31:0] ref_mem [2][256];
    bit          m_o     [2];
    int          m_due   [2];
    bit          m_ls    [2];
    bit          m_st    [2];
    logic [31:0] m_data  [2];
    int          m_wc    [2];
    int          cyc;

    bit e_arb [2];
    bit e_ifw [2];
    bit e_lsw [2];
    bit e_rsp [2];
    bit if_hold [2];
    bit ls_hold [2];

    int n_chk;
    int n_pass;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] widx(input logic [31:0] a);
        return a[9:2];
    endfunction

    task automatic chk32(input string tag, input int d, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
    endtask

    task automatic chk1(input string tag, input int d, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d: observed %b expected %b", tag, d, obs, exp);
    endtask

    task automatic idle(input int d);
        if_req[d] = 1'b0;
        ls_req[d] = 1'b0;
    endtask

    // Check all outputs against the model just before the next rising edge
    task automatic sample();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit frc;
            e_arb[d] = !reset && (!m_o[d] || cyc == m_due[d]);
            frc      = GUARD && (m_wc[d] >= MAX_WAIT) && if_req[d];
            e_ifw[d] = e_arb[d] && if_req[d] && (frc || !ls_req[d]);
            e_lsw[d] = e_arb[d] && ls_req[d] && !e_ifw[d];
            e_rsp[d] = !reset && m_o[d] && cyc == m_due[d];
            chk1("if_gnt", d, if_gnt[d], e_ifw[d]);
            chk1("ls_gnt", d, ls_gnt[d], e_lsw[d]);
            chk1("mem_en", d, mem_en[d], e_ifw[d] || e_lsw[d]);
            chk1("mem_we", d, mem_we[d], e_lsw[d] && ls_we[d]);
            if (e_ifw[d] || e_lsw[d]) begin
                chk32("mem_addr", d, mem_addr[d], e_ifw[d] ? if_addr[d] : ls_addr[d]);
                chk32("mem_be", d, {28'b0, mem_be[d]}, e_ifw[d] ? 32'hf : {28'b0, ls_be[d]});
            end
            if (e_lsw[d] && ls_we[d]) chk32("mem_wdata", d, mem_wdata[d], ls_wdata[d]);
            chk1("if_rvalid", d, if_rvalid[d], e_rsp[d] && !m_ls[d]);
            chk1("ls_rvalid", d, ls_rvalid[d], e_rsp[d] && m_ls[d]);
            if (e_rsp[d]) begin
                chk32("if_rdata", d, if_rdata[d], m_ls[d] ? 32'h0 : m_data[d]);
                chk32("ls_rdata", d, ls_rdata[d], (m_ls[d] && !m_st[d]) ? m_data[d] : 32'h0);
            end
            if (reset) begin
                chk32("rst_mem_addr", d, mem_addr[d], 32'h0);
                chk32("rst_mem_wdata", d, mem_wdata[d], 32'h0);
                chk32("rst_mem_be", d, {28'b0, mem_be[d]}, 32'h0);
                chk32("rst_if_rdata", d, if_rdata[d], 32'h0);
                chk32("rst_ls_rdata", d, ls_rdata[d], 32'h0);
            end
        end
    endtask

    // Advance model and environment memory across the rising edge
    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_o[d]  = 1'b0;
                m_wc[d] = 0;
            end else begin
                if (e_rsp[d]) m_o[d] = 1'b0;
                if (e_ifw[d] || e_lsw[d]) begin
                    m_o[d]   = 1'b1;
                    m_due[d] = cyc + lat_of(d);
                    m_ls[d]  = e_lsw[d];
                    m_st[d]  = e_lsw[d] && ls_we[d];
                    if (m_st[d]) begin
                        for (int b = 0; b < 4; b++)
                            if (ls_be[d][b])
                                ref_mem[d][widx(ls_addr[d])][8*b +: 8] = ls_wdata[d][8*b +: 8];
                        m_data[d] = 32'h0;
                    end else begin
                        m_data[d] = ref_mem[d][widx(e_lsw[d] ? ls_addr[d] : if_addr[d])];
                    end
                end
                if (!if_req[d] || e_ifw[d]) m_wc[d] = 0;
                else if (e_arb[d] && m_wc[d] < MAX_WAIT) m_wc[d]++;
            end
            if_hold[d] = if_req[d] && !e_ifw[d];
            ls_hold[d] = ls_req[d] && !e_lsw[d];
            pipe[d][2] = pipe[d][1];
            pipe[d][1] = pipe[d][0];
            pipe[d][0] = 32'hbad0_bad0;
            if (mem_en[d] === 1'b1) begin
                if (mem_we[d] === 1'b1) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[d][b])
                            env_mem[d][widx(mem_addr[d])][8*b +: 8] = mem_wdata[d][8*b +: 8];
                end else begin
                    pipe[d][0] = env_mem[d][widx(mem_addr[d])];
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) mem_rdata[d] = pipe[d][lat_of(d) - 1];
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        reset  = 1'b1;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            if_addr[d] = 32'h0; ls_we[d] = 1'b0; ls_addr[d] = 32'h0;
            ls_wdata[d] = 32'h0; ls_be[d] = 4'h0; mem_rdata[d] = 32'h0;
            m_o[d] = 1'b0; m_due[d] = 0; m_ls[d] = 1'b0; m_st[d] = 1'b0;
            m_data[d] = 32'h0; m_wc[d] = 0; if_hold[d] = 1'b0; ls_hold[d] = 1'b0;
            for (int k = 0; k < 3; k++) pipe[d][k] = 32'h0;
            for (int i = 0; i < 256; i++) begin
                logic [31:0] v;
                v = $urandom;
                env_mem[d][i] = v;
                ref_mem[d][i] = v;
            end
        end
        env_mem[0][4] = 32'h0050_0093;
        ref_mem[0][4] = 32'h0050_0093;

        step();
        step();
        reset = 1'b0;
        step();

        // Single fetch, MEM_LAT=1
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        sample();
        chk1("fetch_gnt", 0, if_gnt[0], 1'b1);
        chk1("fetch_mem_en", 0, mem_en[0], 1'b1);
        advance();
        if_req[0] = 1'b0;
        sample();
        chk1("fetch_rvalid", 0, if_rvalid[0], 1'b1);
        chk32("fetch_rdata", 0, if_rdata[0], 32'h0050_0093);
        chk1("fetch_ls_quiet", 0, ls_rvalid[0], 1'b0);
        advance();

        // Contention, MEM_LAT=1
        if_req[0] = 1'b1; if_addr[0] = 32'h14;
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 32'h200;
        sample();
        chk1("cont_ls_gnt", 0, ls_gnt[0], 1'b1);
        chk1("cont_if_wait", 0, if_gnt[0], 1'b0);
        advance();
        ls_req[0] = 1'b0;
        sample();
        chk1("cont_if_gnt", 0, if_gnt[0], 1'b1);
        chk1("cont_ls_rvalid", 0, ls_rvalid[0], 1'b1);
        advance();
        if_req[0] = 1'b0;
        sample();
        chk1("cont_if_rvalid", 0, if_rvalid[0], 1'b1);
        advance();
        step();

        // Store ack, MEM_LAT=3
        ls_req[1] = 1'b1; ls_we[1] = 1'b1; ls_addr[1] = 32'h40;
        ls_wdata[1] = 32'hDEAD_BEEF; ls_be[1] = 4'b0011;
        sample();
        chk1("st_mem_we", 1, mem_we[1], 1'b1);
        chk32("st_mem_be", 1, {28'b0, mem_be[1]}, 32'h3);
        advance();
        ls_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 32'h40;
        for (int i = 1; i <= 2; i++) begin
            sample();
            chk1("st_no_if_gnt", 1, if_gnt[1], 1'b0);
            chk1("st_no_mem_en", 1, mem_en[1], 1'b0);
            advance();
        end
        sample();
        chk1("st_ack", 1, ls_rvalid[1], 1'b1);
        chk32("st_ack_rdata", 1, ls_rdata[1], 32'h0);
        chk1("st_regrant", 1, if_gnt[1], 1'b1);
        advance();
        if_req[1] = 1'b0;
        sample();
        advance();
        sample();
        advance();
        sample();
        chk1("st_readback_valid", 1, if_rvalid[1], 1'b1);
        advance();

        // Starvation guard, MEM_LAT=1: continuous LS and IF requests
        if_req[0] = 1'b1; if_addr[0] = 32'h18;
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 32'h100;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk1("starve_if_gnt", 0, if_gnt[0], GUARD && (i % 5 == 4));
            chk1("starve_ls_gnt", 0, ls_gnt[0], !(GUARD && (i % 5 == 4)));
            advance();
        end
        idle(0);
        step();

        // Reset mid-access, MEM_LAT=3
        if_req[1] = 1'b1; if_addr[1] = 32'h20;
        sample();
        chk1("rst_issue", 1, if_gnt[1], 1'b1);
        advance();
        if_req[1] = 1'b0; reset = 1'b1;
        sample();
        chk1("rst_mem_en", 1, mem_en[1], 1'b0);
        advance();
        reset = 1'b0;
        ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h80;
        sample();
        chk1("rst_first_gnt", 1, ls_gnt[1], 1'b1);
        advance();
        ls_req[1] = 1'b0;
        sample();
        chk1("rst_no_rvalid", 1, if_rvalid[1], 1'b0);
        advance();
        step();
        step();

        // Withdrawn IF request during WAIT, MEM_LAT=3
        ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h84;
        sample();
        chk1("wd_ls_gnt", 1, ls_gnt[1], 1'b1);
        advance();
        ls_req[1] = 1'b0; if_req[1] = 1'b1; if_addr[1] = 32'h24;
        sample();
        chk1("wd_no_gnt", 1, if_gnt[1], 1'b0);
        advance();
        if_req[1] = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            sample();
            chk1("wd_no_if_gnt", 1, if_gnt[1], 1'b0);
            chk1("wd_no_if_rvalid", 1, if_rvalid[1], 1'b0);
            advance();
        end

        // Randomized traffic honouring the hold-while-waiting rule
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom % 64 == 0);
            for (int d = 0; d < 2; d++) begin
                if (if_hold[d]) begin
                    if ($urandom % 8 == 0) if_req[d] = 1'b0;
                end else begin
                    if_req[d]  = ($urandom % 2 == 0);
                    if_addr[d] = 32'($urandom % 256) << 2;
                end
                if (ls_hold[d]) begin
                    if ($urandom % 8 == 0) ls_req[d] = 1'b0;
                end else begin
                    ls_req[d]   = ($urandom % 4 != 0);
                    ls_we[d]    = ($urandom % 2 == 0);
                    ls_addr[d]  = 32'($urandom % 256) << 2;
                    ls_wdata[d] = $urandom;
                    ls_be[d]    = 4'($urandom);
                end
            end
            step();
        end
        reset = 1'b0;
        for (int d = 0; d < 2; d++) idle(d);
        for (int n = 0; n < 4; n++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
